fixed_mult_iter: RTL and testbench

FIXED_MULT_ITER -- requirements
Module: fixed_mult_iter

---
 rtl/fixed_mult_iter.sv | 86 ++++++++
 tb/tb_fixed_mult_iter.sv | 111 +++++++++++
 2 files changed

// File: rtl/fixed_mult_iter.sv
// fixed_mult_iter: iterative fixed-point multiplier, k multiplier bits per cycle, optional signed/saturating result
module fixed_mult_iter #(
    parameter int n      = 32,
    parameter int d      = 16,
    parameter int k      = 1,
    parameter int SIGNED = 1,
    parameter int SAT    = 0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           recv_val,
    output logic           recv_rdy,
    input  logic [2*n-1:0] recv_msg,
    output logic           send_val,
    input  logic           send_rdy,
    output logic [n-1:0]   send_msg
);
    localparam int NI = n / k;
    localparam int CW = $clog2(NI + 1);
    localparam logic [2*n-1:0] PMAX = {{(n+1){1'b0}}, {(n-1){1'b1}}};
    localparam logic [2*n-1:0] NMAX = {{n{1'b0}}, 1'b1, {(n-1){1'b0}}};
    localparam logic [2*n-1:0] UMAX = {{n{1'b0}}, {n{1'b1}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         state_q;
    logic [2*n-1:0] a_q, acc_q, acc_d, m;
    logic [n-1:0]   b_q, msg_q, a_in, b_in, a_mag, b_mag, rn, res;
    logic [CW-1:0]  cnt_q;
    logic           sign_q, sign_d;

    always_comb begin
        a_in   = recv_msg[2*n-1:n];
        b_in   = recv_msg[n-1:0];
        a_mag  = (SIGNED != 0 && a_in[n-1]) ? ~a_in + n'(1) : a_in;
        b_mag  = (SIGNED != 0 && b_in[n-1]) ? ~b_in + n'(1) : b_in;
        sign_d = SIGNED != 0 && (a_in[n-1] ^ b_in[n-1]);
        acc_d  = acc_q + a_q * (2*n)'(b_q[k-1:0]);
        m      = acc_d >> d;
        rn     = sign_q ? ~m[n-1:0] + n'(1) : m[n-1:0];
        // Signed saturation compares the magnitude, so -2^(n-1) is still exact
        res    = SAT == 0 ? rn
               : SIGNED != 0 ? (!sign_q && m > PMAX ? {1'b0, {(n-1){1'b1}}}
                              : sign_q && m > NMAX ? {1'b1, {(n-1){1'b0}}} : rn)
               : (m > UMAX ? {n{1'b1}} : m[n-1:0]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            msg_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (recv_val) begin
                    a_q     <= {{n{1'b0}}, a_mag};
                    b_q     <= b_mag;
                    sign_q  <= sign_d;
                    acc_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= CALC;
                end
                CALC: begin
                    acc_q <= acc_d;
                    a_q   <= a_q << k;
                    b_q   <= b_q >> k;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(NI - 1)) begin
                        msg_q   <= res;
                        state_q <= DONE;
                    end
                end
                DONE: if (send_rdy) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign recv_rdy = state_q == IDLE && !reset;
    assign send_val = state_q == DONE && !reset;
    assign send_msg = msg_q;
endmodule

// File: tb/tb_fixed_mult_iter.sv
// tb_fixed_mult_iter: directed checks of the iterative multiplier in three configurations
module tb_fixed_mult_iter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] msg = '0;
    logic        rv [3];
    logic        sr [3];
    logic        rr [3];
    logic        sv [3];
    logic [31:0] sm [3];
    int          lat [3] = '{32, 8, 32};
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    fixed_mult_iter u0 (.clk(clk), .reset(reset), .recv_val(rv[0]), .recv_rdy(rr[0]), .recv_msg(msg),
                        .send_val(sv[0]), .send_rdy(sr[0]), .send_msg(sm[0]));
    fixed_mult_iter #(.k(4)) u1 (.clk(clk), .reset(reset), .recv_val(rv[1]), .recv_rdy(rr[1]), .recv_msg(msg),
                        .send_val(sv[1]), .send_rdy(sr[1]), .send_msg(sm[1]));
    fixed_mult_iter #(.SAT(1)) u2 (.clk(clk), .reset(reset), .recv_val(rv[2]), .recv_rdy(rr[2]), .recv_msg(msg),
                        .send_val(sv[2]), .send_rdy(sr[2]), .send_msg(sm[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic op(input int u, input logic [31:0] a, input logic [31:0] b, input logic [31:0] e, input int hold);
        int w = 0;
        while (!rr[u] && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        check("ready before accept", 32'(rr[u]), 1);
        msg = {a, b};
        rv[u] = 1'b1;
        @(posedge clk); #1;
        rv[u] = 1'b0;
        msg = {$urandom, $urandom};
        check("rdy low in calc", 32'(rr[u]), 0);
        repeat (lat[u] - 1) @(posedge clk);
        #1 check("valid not early", 32'(sv[u]), 0);
        @(posedge clk); #1;
        check("valid on time", 32'(sv[u]), 1);
        check("result", sm[u], e);
        for (int i = 0; i < hold; i++) begin
            msg = {$urandom, $urandom};
            rv[u] = 1'b1;
            @(posedge clk); #1;
            check("hold valid", 32'(sv[u]), 1);
            check("hold result", sm[u], e);
            check("hold rdy low", 32'(rr[u]), 0);
        end
        rv[u] = 1'b0;
        sr[u] = 1'b1;
        @(posedge clk); #1;
        sr[u] = 1'b0;
        check("valid drops", 32'(sv[u]), 0);
        check("idle after send", 32'(rr[u]), 1);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rv[i] = 1'b0;
            sr[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1 check("reset rdy", 32'(rr[0]), 0);
        check("reset val", 32'(sv[0]), 0);
        check("reset msg", sm[0], 0);
        reset = 1'b0;
        #1 check("rdy after reset", 32'(rr[0]), 1);

        op(0, 32'h0001_8000, 32'h0002_0000, 32'h0003_0000, 0);
        op(1, 32'hFFFE_8000, 32'h0002_0000, 32'hFFFD_0000, 0);
        op(0, 32'h00C8_0000, 32'h00C8_0000, 32'h9C40_0000, 0);
        op(2, 32'h00C8_0000, 32'h00C8_0000, 32'h7FFF_FFFF, 0);
        op(2, 32'hFF38_0000, 32'h00C8_0000, 32'h8000_0000, 0);
        op(2, 32'h8000_0000, 32'h0001_0000, 32'h8000_0000, 0);
        op(0, 32'h8000_0000, 32'h0001_0000, 32'h8000_0000, 0);
        op(0, 32'hFFFF_FFFF, 32'h0000_8000, 32'h0000_0000, 0);
        op(1, 32'h0003_0000, 32'hFFFF_C000, 32'hFFFF_4000, 0);
        op(0, 32'h0001_8000, 32'h0002_0000, 32'h0003_0000, 10);

        msg = {32'h0005_0000, 32'h0005_0000};
        rv[0] = 1'b1;
        @(posedge clk); #1;
        rv[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        check("mid reset rdy", 32'(rr[0]), 0);
        check("mid reset val", 32'(sv[0]), 0);
        reset = 1'b0;
        #1 check("rdy after abort", 32'(rr[0]), 1);
        begin
            int seen = 0;
            for (int i = 0; i < 40; i++) begin
                @(posedge clk); #1;
                if (sv[0]) seen = 1;
            end
            check("aborted never valid", 32'(seen), 0);
        end
        op(0, 32'h0003_0000, 32'h0000_4000, 32'h0000_C000, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
